// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, NOP encoding, reset PC.
package fetch_pkg;

    localparam int unsigned ILEN = 32;

    localparam logic [31:0] FETCH_NOP = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0040_0000;

    typedef enum logic [1:0] {
        FETCH_REQ   = 2'd0,
        FETCH_WAIT  = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched {pc, instr[, misaligned]} entries; clear empties it in one edge.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic                   head_valid,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];
    assign do_pop     = pop & head_valid & ~clear;
    assign do_push    = push & ~clear & ((count != CNT_W'(DEPTH)) | do_pop);

    // Pointers and occupancy; clear wins over push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage is zeroed on reset so the head reads zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding imem requests, credit-based buffering, PC stall control.
// Optional FETCH_MISALIGN_CHECK_EN turns misaligned PCs into flagged NOP entries.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    pc_value,
    output logic            stall,
    input  logic            flush,
    output logic            imem_req_valid,
    output logic [N-1:0]    imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    output logic [ILEN-1:0] instr,
    output logic [N-1:0]    instr_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic            instr_misaligned,
`endif
    input  logic            instr_ready
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam int unsigned ENTRY_W = N + ILEN + 1;
`else
    localparam int unsigned ENTRY_W = N + ILEN;
`endif

    fetch_state_e        state;
    fetch_state_e        state_next;
    logic [N-1:0]        pend_pc;
    logic                pend_load;
    logic [CNT_W-1:0]    count;
    logic                credit;
    logic                pc_misaligned;
    logic                push;
    logic                mis_push;
    logic [N-1:0]        push_pc;
    logic [ILEN-1:0]     push_instr;
    logic [ENTRY_W-1:0]  push_data;
    logic [ENTRY_W-1:0]  head_data;

    // A request in flight reserves one buffer slot so its response always fits.
    assign credit = (count + CNT_W'(state == FETCH_WAIT)) < CNT_W'(DEPTH);

`ifdef FETCH_MISALIGN_CHECK_EN
    assign pc_misaligned = (pc_value[1:0] != 2'b00);
`else
    assign pc_misaligned = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH_REQ;
            pend_pc <= '0;
        end else begin
            state <= state_next;
            if (pend_load) pend_pc <= pc_value;
        end
    end

    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        pend_load      = 1'b0;
        push           = 1'b0;
        mis_push       = 1'b0;
        case (state)
            FETCH_REQ: begin
                if (credit && !flush && !reset) begin
                    if (pc_misaligned) begin
                        mis_push = 1'b1;
                        push     = 1'b1;
                    end else begin
                        imem_req_valid = 1'b1;
                        if (imem_req_ready) begin
                            pend_load  = 1'b1;
                            state_next = FETCH_WAIT;
                        end
                    end
                end
            end
            FETCH_WAIT: begin
                if (imem_rsp_valid) begin
                    push       = !flush;
                    state_next = FETCH_REQ;
                end else if (flush) begin
                    state_next = FETCH_DRAIN;
                end
            end
            // A flushed request's response is still owed; swallow it before refetching.
            FETCH_DRAIN: begin
                if (imem_rsp_valid) state_next = FETCH_REQ;
            end
            default: state_next = FETCH_REQ;
        endcase
    end

    assign imem_req_addr = pc_value;
    assign stall = reset | (~(imem_req_valid & imem_req_ready) & ~mis_push & ~flush);

    assign push_pc    = mis_push ? pc_value : pend_pc;
    assign push_instr = mis_push ? FETCH_NOP : imem_rsp_data;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign push_data = {push_pc, push_instr, mis_push};
    assign {instr_pc, instr, instr_misaligned} = head_data;
`else
    assign push_data = {push_pc, push_instr};
    assign {instr_pc, instr} = head_data;
`endif

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (flush),
        .push       (push),
        .push_data  (push_data),
        .pop        (instr_valid & instr_ready),
        .head_valid (instr_valid),
        .head_data  (head_data),
        .count      (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model, directed scenarios, random traffic.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned N     = 32;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  pc_value;
    logic          stall;
    logic          flush;
    logic          imem_req_valid;
    logic [N-1:0]  imem_req_addr;
    logic          imem_req_ready;
    logic          imem_rsp_valid;
    logic [31:0]   imem_rsp_data;
    logic          instr_valid;
    logic [31:0]   instr;
    logic [N-1:0]  instr_pc;
    logic          instr_ready;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic          instr_misaligned;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.N(N), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_value       (pc_value),
        .stall          (stall),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
        .instr_misaligned (instr_misaligned),
`endif
        .instr_ready    (instr_ready)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        mis;
    } ent_t;

    // Reference model: buffered entries, "response owed and kept", "response owed and dropped".
    ent_t        q[$];
    bit          m_out, m_drop;
    logic [31:0] m_pend, m_pc;
    // Memory model
    bit          mem_busy;
    int          mem_lat;
    logic [31:0] mem_addr;
    // Per-cycle stimulus knobs
    bit          k_reset, k_flush, k_ready, k_iready;
    int          k_lat;
    logic [31:0] k_target;
    // Expectations for the current cycle
    bit          e_req, e_mpush, e_stall;
    int          n_tests, n_fail, hs_count;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == RESET_PC) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive_and_check();
        bit credit, mis;
        @(negedge clk);
        if (k_reset) begin
            q.delete();
            m_out  = 0;
            m_drop = 0;
            m_pc   = RESET_PC;
        end
        reset          = k_reset;
        flush          = k_flush;
        instr_ready    = k_iready;
        pc_value       = m_pc;
        imem_req_ready = k_ready && !mem_busy;
        imem_rsp_valid = mem_busy && (mem_lat == 1);
        imem_rsp_data  = imem_rsp_valid ? mem_data(mem_addr) : $urandom;
        #1;
        credit = (q.size() + (m_out ? 1 : 0)) < DEPTH;
`ifdef FETCH_MISALIGN_CHECK_EN
        mis = (m_pc[1:0] != 2'b00);
`else
        mis = 0;
`endif
        e_req   = !k_reset && !m_out && !m_drop && credit && !k_flush && !mis;
        e_mpush = !k_reset && !m_out && !m_drop && credit && !k_flush && mis;
        e_stall = k_reset || (!(e_req && k_ready && !mem_busy) && !e_mpush && !k_flush);
        check("req_valid", 32'(imem_req_valid), 32'(e_req));
        check("stall", 32'(stall), 32'(e_stall));
        if (e_req) check("req_addr", imem_req_addr, m_pc);
        check("instr_valid", 32'(instr_valid), 32'(q.size() != 0));
        if (k_reset) begin
            check("rst_instr", instr, 32'h0);
            check("rst_instr_pc", instr_pc, 32'h0);
        end else if (q.size() != 0) begin
            check("instr", instr, q[0].ins);
            check("instr_pc", instr_pc, q[0].pc);
`ifdef FETCH_MISALIGN_CHECK_EN
            check("misaligned", 32'(instr_misaligned), 32'(q[0].mis));
`endif
        end
    endtask

    task automatic advance();
        bit          hs, pop, have_push;
        ent_t        pe;
        logic [31:0] pc_now;
        @(posedge clk);
        pc_now    = m_pc;
        hs        = e_req && imem_req_ready;
        have_push = 0;
        pe        = '0;
        if (!k_reset) begin
            pop = (q.size() != 0) && k_iready;
            if (m_out && imem_rsp_valid && !k_flush) begin
                pe.pc = m_pend; pe.ins = imem_rsp_data; pe.mis = 1'b0; have_push = 1;
            end
            if (e_mpush) begin
                pe.pc = m_pc; pe.ins = FETCH_NOP; pe.mis = 1'b1; have_push = 1;
            end
            if (k_flush) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (have_push) q.push_back(pe);
            end
            if (m_out) begin
                if (imem_rsp_valid) m_out = 0;
                else if (k_flush) begin m_out = 0; m_drop = 1; end
            end else if (m_drop) begin
                if (imem_rsp_valid) m_drop = 0;
            end else if (hs) begin
                m_out = 1; m_pend = m_pc; hs_count++;
            end
            if (k_flush) m_pc = k_target;
            else if (!e_stall) m_pc = m_pc + 32'd4;
        end
        if (mem_busy) begin
            if (mem_lat == 1) mem_busy = 0;
            else mem_lat--;
        end
        if (hs) begin
            mem_busy = 1; mem_lat = k_lat; mem_addr = pc_now;
        end
    endtask

    task automatic cyc();
        drive_and_check();
        advance();
    endtask

    task automatic reset_pulse();
        k_reset = 1; k_flush = 0;
        cyc();
        k_reset = 0;
        hs_count = 0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; hs_count = 0;
        mem_busy = 0; mem_lat = 0; mem_addr = '0;
        m_out = 0; m_drop = 0; m_pend = '0; m_pc = RESET_PC;
        reset = 1; flush = 0; pc_value = RESET_PC; imem_req_ready = 0;
        imem_rsp_valid = 0; imem_rsp_data = '0; instr_ready = 0;
        k_reset = 1; k_flush = 0; k_ready = 1; k_iready = 0; k_lat = 1; k_target = RESET_PC;

        // Reset state
        drive_and_check();
        check("lit_rst_stall", 32'(stall), 32'd1);
        check("lit_rst_valid", 32'(instr_valid), 32'd0);
        advance();
        cyc();

        // Basic fetch followed by backpressure with decode stalled
        k_reset = 0; hs_count = 0;
        drive_and_check();
        check("lit_basic_req", 32'(imem_req_valid), 32'd1);
        check("lit_basic_stall", 32'(stall), 32'd0);
        check("lit_basic_addr", imem_req_addr, 32'h0040_0000);
        advance();
        drive_and_check();
        check("lit_basic_wait_stall", 32'(stall), 32'd1);
        check("lit_basic_wait_valid", 32'(instr_valid), 32'd0);
        advance();
        drive_and_check();
        check("lit_basic_valid", 32'(instr_valid), 32'd1);
        check("lit_basic_instr", instr, 32'h0050_0093);
        check("lit_basic_pc", instr_pc, 32'h0040_0000);
        advance();
        for (int i = 0; i < 6; i++) cyc();
        check("lit_bp_requests", 32'(hs_count), 32'd2);
        drive_and_check();
        check("lit_bp_req", 32'(imem_req_valid), 32'd0);
        check("lit_bp_stall", 32'(stall), 32'd1);
        advance();
        k_iready = 1;
        cyc();
        k_iready = 0;
        drive_and_check();
        check("lit_bp_resume", 32'(imem_req_valid), 32'd1);
        advance();
        k_iready = 1;
        for (int i = 0; i < 6; i++) cyc();

        // Flush in WAIT, response arrives 3 cycles after the flush
        reset_pulse();
        k_lat = 4;
        cyc();
        k_flush = 1; k_target = 32'h0040_1000;
        drive_and_check();
        check("lit_fw_stall", 32'(stall), 32'd0);
        advance();
        k_flush = 0; k_lat = 1;
        for (int i = 0; i < 3; i++) begin
            drive_and_check();
            check("lit_fw_drain_req", 32'(imem_req_valid), 32'd0);
            advance();
        end
        drive_and_check();
        check("lit_fw_new_req", 32'(imem_req_valid), 32'd1);
        check("lit_fw_new_addr", imem_req_addr, 32'h0040_1000);
        check("lit_fw_empty", 32'(instr_valid), 32'd0);
        advance();

        // Flush coincident with the response
        k_flush = 1; k_target = 32'h0040_2000;
        drive_and_check();
        check("lit_fr_rsp", 32'(imem_rsp_valid), 32'd1);
        advance();
        k_flush = 0;
        drive_and_check();
        check("lit_fr_valid", 32'(instr_valid), 32'd0);
        check("lit_fr_addr", imem_req_addr, 32'h0040_2000);
        advance();
        for (int i = 0; i < 4; i++) cyc();

`ifdef FETCH_MISALIGN_CHECK_EN
        // Misaligned PC becomes a flagged NOP without touching memory
        reset_pulse();
        k_flush = 1; k_target = 32'h0040_0002;
        cyc();
        k_flush = 0; k_iready = 0;
        drive_and_check();
        check("lit_mis_req", 32'(imem_req_valid), 32'd0);
        check("lit_mis_stall", 32'(stall), 32'd0);
        advance();
        drive_and_check();
        check("lit_mis_instr", instr, 32'h0000_0013);
        check("lit_mis_pc", instr_pc, 32'h0040_0002);
        check("lit_mis_flag", 32'(instr_misaligned), 32'd1);
        advance();
        k_iready = 1; k_flush = 1; k_target = 32'h0040_3000;
        cyc();
        k_flush = 0;
        for (int i = 0; i < 4; i++) cyc();
`endif

        // Asynchronous reset while a response is pending
        reset_pulse();
        k_lat = 3;
        cyc();
        k_reset = 1;
        drive_and_check();
        check("lit_ar_req", 32'(imem_req_valid), 32'd0);
        check("lit_ar_stall", 32'(stall), 32'd1);
        check("lit_ar_instr", instr, 32'h0);
        advance();
        k_reset = 0; k_lat = 1;
        cyc();
        drive_and_check();
        check("lit_ar_late_rsp", 32'(imem_rsp_valid), 32'd1);
        advance();
        drive_and_check();
        check("lit_ar_ignored", 32'(instr_valid), 32'd0);
        advance();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            k_reset  = ($urandom_range(0, 199) == 0);
            k_flush  = ($urandom_range(0, 7) == 0);
            k_ready  = ($urandom_range(0, 3) != 0);
            k_iready = ($urandom_range(0, 2) != 0);
            k_lat    = $urandom_range(1, 3);
            k_target = $urandom & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_CHECK_EN
            if ($urandom_range(0, 5) == 0) k_target[1:0] = 2'($urandom_range(1, 3));
`endif
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
